// File: rtl/uart_query_engine.sv
// ---------------------------------------------------------------------------
// uart_query_engine
//
// Request/response sequencer for the rxtx_uart byte interface. A request
// string is loaded into a small buffer at runtime. Each start pulse sends the
// whole buffer byte by byte to the UART transmitter, then scans the reply for
// a TRUE_CHAR / FALSE_CHAR verdict byte. A TERM_CHAR with no verdict, or a
// reply gap of TIMEOUT_CYC cycles, resends the request up to MAX_RETRY times
// before the query gives up with timed_out. Verdict flags are held until the
// next accepted start.
//
// Ports
//   clk, reset                   system clock, asynchronous active-low reset
//   req_clear                    empty the request buffer (ignored while busy)
//   req_wr_en, req_wr_data       append one byte (dropped while busy or full)
//   req_len, req_full            buffer fill level and full flag
//   start                        one-cycle pulse, runs one query when idle
//   tx_empty, ld_tx_data,
//   tx_data                      UART transmitter handshake
//   rx_empty, rx_data,
//   uld_rx_data                  UART receiver handshake
//   busy, complete               engine status, end-of-query pulse
//   result_true, result_false,
//   timed_out                    latched verdict of the last query
//   last_byte                    most recent byte taken from the receiver
// ---------------------------------------------------------------------------
module uart_query_engine #(
    parameter int unsigned REQ_DEPTH   = 64,
    parameter int unsigned TIMEOUT_CYC = 50_000_000,
    parameter int unsigned MAX_RETRY   = 2,
    parameter logic [7:0]  TRUE_CHAR   = 8'h74,
    parameter logic [7:0]  FALSE_CHAR  = 8'h66,
    parameter logic [7:0]  TERM_CHAR   = 8'h0A
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        req_clear,
    input  logic                        req_wr_en,
    input  logic [7:0]                  req_wr_data,
    output logic [$clog2(REQ_DEPTH):0]  req_len,
    output logic                        req_full,
    input  logic                        start,
    input  logic                        tx_empty,
    output logic                        ld_tx_data,
    output logic [7:0]                  tx_data,
    input  logic                        rx_empty,
    input  logic [7:0]                  rx_data,
    output logic                        uld_rx_data,
    output logic                        busy,
    output logic                        complete,
    output logic                        result_true,
    output logic                        result_false,
    output logic                        timed_out,
    output logic [7:0]                  last_byte
);

    localparam int IDX_W = $clog2(REQ_DEPTH);
    localparam int LEN_W = IDX_W + 1;
    localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(REQ_DEPTH);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

    // TX_BUSY is split in two so the "tx_empty low, then high" handshake
    // needs no extra flag.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_TX_LOW,
        ST_TX_HIGH,
        ST_RECV,
        ST_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       buf_mem [REQ_DEPTH];
    logic [LEN_W-1:0] req_len_q, req_len_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic [RTY_W-1:0] retry_q, retry_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             rx_blank_q, rx_blank_d;
    logic             result_true_q, result_true_d;
    logic             result_false_q, result_false_d;
    logic             timed_out_q, timed_out_d;
    logic [7:0]       last_byte_q, last_byte_d;

    // ------------------------------------------------------------------
    // Shared decode
    // ------------------------------------------------------------------
    logic idle, buf_wr, start_go, rx_take;
    logic hit_true, hit_false, hit_term, tmr_expire, retry_evt, retry_ok, tx_last;

    assign idle       = (state_q == ST_IDLE);
    assign buf_wr     = req_wr_en && idle && !req_clear && (req_len_q != LEN_FULL);
    assign start_go   = start && idle;
    // The cycle after an unload is blanked so rx_empty can settle.
    assign rx_take    = (state_q == ST_RECV) && !rx_blank_q && !rx_empty;
    assign hit_true   = rx_take && (rx_data == TRUE_CHAR);
    assign hit_false  = rx_take && (rx_data == FALSE_CHAR);
    assign hit_term   = rx_take && (rx_data == TERM_CHAR);
    // A byte in the expiry cycle takes priority over the timeout.
    assign tmr_expire = (state_q == ST_RECV) && !rx_take && (timer_q == TMR_LAST);
    assign retry_evt  = hit_term || tmr_expire;
    assign retry_ok   = (retry_q < RTY_MAX);
    assign tx_last    = (LEN_W'(index_q) == req_len_q - LEN_W'(1));

    // ------------------------------------------------------------------
    // Request buffer storage
    // ------------------------------------------------------------------
    // NOTE: the storage array has no reset; clearing req_len_q is what
    // empties the buffer, and leaving the array unreset keeps it in plain RAM.
    always_ff @(posedge clk) begin
        if (buf_wr) begin
            buf_mem[req_len_q[IDX_W-1:0]] <= req_wr_data;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: a default for every combinational output on entry means no
        // path can leave one unassigned, so no latch is inferred.
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start_go) state_d = (req_len_q == '0) ? ST_DONE : ST_SEND;
            ST_SEND:    if (tx_empty) state_d = ST_TX_LOW;
            ST_TX_LOW:  if (!tx_empty) state_d = ST_TX_HIGH;
            ST_TX_HIGH: if (tx_empty) state_d = tx_last ? ST_RECV : ST_SEND;
            ST_RECV: begin
                if (hit_true || hit_false) begin
                    state_d = ST_DONE;
                end else if (retry_evt) begin
                    state_d = retry_ok ? ST_SEND : ST_DONE;
                end
            end
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        ld_tx_data  = 1'b0;
        tx_data     = 8'h00;
        uld_rx_data = 1'b0;
        complete    = 1'b0;
        busy        = 1'b1;
        case (state_q)
            ST_IDLE: busy = 1'b0;
            ST_SEND: begin
                if (tx_empty) begin
                    ld_tx_data = 1'b1;
                    tx_data    = buf_mem[index_q];
                end
            end
            ST_RECV: uld_rx_data = rx_take;
            ST_DONE: complete = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: buffer length, index, retry, timer, verdicts
    // ------------------------------------------------------------------
    always_comb begin
        req_len_d      = req_len_q;
        index_d        = index_q;
        retry_d        = retry_q;
        timer_d        = timer_q;
        rx_blank_d     = 1'b0;
        result_true_d  = result_true_q;
        result_false_d = result_false_q;
        timed_out_d    = timed_out_q;
        last_byte_d    = last_byte_q;

        if (req_clear && idle) begin
            req_len_d = '0;
        end else if (buf_wr) begin
            req_len_d = req_len_q + LEN_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start_go) begin
                    result_true_d  = 1'b0;
                    result_false_d = 1'b0;
                    timed_out_d    = 1'b0;
                    index_d        = '0;
                    retry_d        = '0;
                end
            end
            ST_TX_HIGH: begin
                if (tx_empty) begin
                    index_d = index_q + IDX_W'(1);
                    timer_d = '0;
                end
            end
            ST_RECV: begin
                if (rx_take) begin
                    last_byte_d = rx_data;
                    timer_d     = '0;
                    rx_blank_d  = 1'b1;
                end else if (!tmr_expire) begin
                    timer_d = timer_q + TMR_W'(1);
                end
                if (hit_true)  result_true_d  = 1'b1;
                if (hit_false) result_false_d = 1'b1;
                if (retry_evt) begin
                    if (retry_ok) begin
                        retry_d = retry_q + RTY_W'(1);
                        index_d = '0;
                    end else begin
                        timed_out_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_len_q      <= '0;
            index_q        <= '0;
            retry_q        <= '0;
            timer_q        <= '0;
            rx_blank_q     <= 1'b0;
            result_true_q  <= 1'b0;
            result_false_q <= 1'b0;
            timed_out_q    <= 1'b0;
            last_byte_q    <= 8'h00;
        end else begin
            req_len_q      <= req_len_d;
            index_q        <= index_d;
            retry_q        <= retry_d;
            timer_q        <= timer_d;
            rx_blank_q     <= rx_blank_d;
            result_true_q  <= result_true_d;
            result_false_q <= result_false_d;
            timed_out_q    <= timed_out_d;
            last_byte_q    <= last_byte_d;
        end
    end

    assign req_len      = req_len_q;
    assign req_full     = (req_len_q == LEN_FULL);
    assign result_true  = result_true_q;
    assign result_false = result_false_q;
    assign timed_out    = timed_out_q;
    assign last_byte    = last_byte_q;

endmodule

// File: tb/tb_uart_query_engine.sv
// ---------------------------------------------------------------------------
// tb_uart_query_engine
//
// Scoreboard bench for uart_query_engine. Each query is run through a
// behavioural model that pushes the expected transmit bytes and the expected
// end-of-query result into queues; a monitor pops and compares whenever the
// DUT strobes ld_tx_data or complete. A UART model answers the DUT with
// scripted reply "attempts", one per full transmission of the request.
// ---------------------------------------------------------------------------
module tb_uart_query_engine;

    localparam int         DEPTH   = 64;
    localparam int         TO_CYC  = 100;
    localparam int         RETRIES = 1;
    localparam logic [7:0] TRUE_C  = 8'h74;
    localparam logic [7:0] FALSE_C = 8'h66;
    localparam logic [7:0] TERM_C  = 8'h0A;

    typedef struct packed {
        logic        rt;
        logic        rf;
        logic        to;
        logic        chk_to;
        logic [15:0] n_ld;
        logic [15:0] n_uld;
        logic [7:0]  last;
    } exp_t;

    logic       clk, reset;
    logic       req_clear, req_wr_en, start;
    logic [7:0] req_wr_data;
    logic [6:0] req_len;
    logic       req_full, tx_empty, ld_tx_data, rx_empty, uld_rx_data;
    logic [7:0] tx_data, rx_data, last_byte;
    logic       busy, complete, result_true, result_false, timed_out;

    uart_query_engine #(
        .REQ_DEPTH(DEPTH), .TIMEOUT_CYC(TO_CYC), .MAX_RETRY(RETRIES),
        .TRUE_CHAR(TRUE_C), .FALSE_CHAR(FALSE_C), .TERM_CHAR(TERM_C)
    ) dut (
        .clk(clk), .reset(reset),
        .req_clear(req_clear), .req_wr_en(req_wr_en), .req_wr_data(req_wr_data),
        .req_len(req_len), .req_full(req_full), .start(start),
        .tx_empty(tx_empty), .ld_tx_data(ld_tx_data), .tx_data(tx_data),
        .rx_empty(rx_empty), .rx_data(rx_data), .uld_rx_data(uld_rx_data),
        .busy(busy), .complete(complete),
        .result_true(result_true), .result_false(result_false),
        .timed_out(timed_out), .last_byte(last_byte)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard state
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_tx[$];
    exp_t       exp_done[$];
    exp_t       cur_exp;
    logic [7:0] exp_last = 8'h00;

    // Current query script
    logic [7:0] cur_req[$];
    int         cur_att_len[$];
    logic [7:0] cur_att_data[$];

    // UART model state
    int         uart_att_len[$];
    logic [7:0] uart_att_data[$];
    logic [7:0] rx_pend[$];
    int         cur_len = 0;
    int         sent_count = 0;
    int         tx_cnt = 0;
    int         rx_gap = 0;
    int         m_alen;
    logic       seen_ld, seen_uld;

    // Monitor state
    int   n_complete = 0;
    int   ld_total = 0;
    int   q_ld = 0;
    int   q_uld = 0;
    int   complete_cyc = 0;
    int   last_ld_cyc = 0;
    int   start_cyc = 0;
    exp_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
        end
    endtask

    // Reference model: send the request, walk the reply of each attempt,
    // retry on terminator or silence, until a verdict or retries run out.
    task automatic model_query();
        exp_t       e;
        int         tries, p, alen;
        bit         fin, silent;
        logic [7:0] c;
        e       = '0;
        e.last  = exp_last;
        tries   = 0;
        p       = 0;
        fin     = (cur_req.size() == 0);
        while (!fin) begin
            foreach (cur_req[i]) exp_tx.push_back(cur_req[i]);
            e.n_ld = e.n_ld + 16'(cur_req.size());
            alen   = (tries < cur_att_len.size()) ? cur_att_len[tries] : 0;
            silent = (alen == 0);
            for (int i = 0; i < alen; i++) begin
                c       = cur_att_data[p + i];
                e.n_uld = e.n_uld + 16'd1;
                e.last  = c;
                if (c == TRUE_C)  begin e.rt = 1'b1; fin = 1'b1; break; end
                if (c == FALSE_C) begin e.rf = 1'b1; fin = 1'b1; break; end
                if (c == TERM_C)  break;
            end
            p += alen;
            if (!fin) begin
                if (tries < RETRIES) begin
                    tries++;
                end else begin
                    e.to     = 1'b1;
                    e.chk_to = silent;
                    fin      = 1'b1;
                end
            end
        end
        exp_last = e.last;
        cur_exp  = e;
        exp_done.push_back(e);
    endtask

    // UART model: acts just after each rising edge on what the DUT strobed
    // in the cycle before.
    initial begin
        tx_empty = 1'b1;
        rx_empty = 1'b1;
        rx_data  = 8'h00;
        forever begin
            @(negedge clk);
            seen_ld  = ld_tx_data;
            seen_uld = uld_rx_data;
            @(posedge clk);
            #1;
            if (!reset) begin
                tx_empty = 1'b1;
                rx_empty = 1'b1;
                rx_data  = 8'h00;
                rx_pend.delete();
                uart_att_len.delete();
                uart_att_data.delete();
                sent_count = 0;
            end else begin
                if (seen_ld) begin
                    tx_empty = 1'b0;
                    tx_cnt   = $urandom_range(1, 4);
                    sent_count++;
                    if (sent_count == cur_len) begin
                        sent_count = 0;
                        if (uart_att_len.size() > 0) begin
                            m_alen = uart_att_len.pop_front();
                            repeat (m_alen) rx_pend.push_back(uart_att_data.pop_front());
                        end
                    end
                end else if (!tx_empty) begin
                    if (tx_cnt == 0) tx_empty = 1'b1;
                    else tx_cnt--;
                end
                if (seen_uld) begin
                    rx_empty = 1'b1;
                    rx_gap   = $urandom_range(0, 4);
                end else if (rx_empty && rx_pend.size() > 0) begin
                    if (rx_gap == 0) begin
                        rx_data  = rx_pend.pop_front();
                        rx_empty = 1'b0;
                    end else begin
                        rx_gap--;
                    end
                end
            end
        end
    end

    // Monitor
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                q_ld  = 0;
                q_uld = 0;
            end else begin
                if (ld_tx_data) begin
                    ld_total++;
                    q_ld++;
                    last_ld_cyc = cyc;
                    check("tx_expected", exp_tx.size() != 0, 1);
                    if (exp_tx.size() != 0) check("tx_data", tx_data, exp_tx.pop_front());
                end
                if (uld_rx_data) q_uld++;
                if (complete) begin
                    n_complete++;
                    complete_cyc = cyc;
                    check("complete_expected", exp_done.size() != 0, 1);
                    if (exp_done.size() != 0) begin
                        mon_e = exp_done.pop_front();
                        check("result_true", result_true, mon_e.rt);
                        check("result_false", result_false, mon_e.rf);
                        check("timed_out", timed_out, mon_e.to);
                        check("ld_count", q_ld, mon_e.n_ld);
                        check("uld_count", q_uld, mon_e.n_uld);
                        check("last_byte", last_byte, mon_e.last);
                        check("busy_at_done", busy, 1);
                        if (mon_e.chk_to)
                            check_range("timeout_latency", complete_cyc - last_ld_cyc, TO_CYC + 2, TO_CYC + 10);
                    end
                    q_ld  = 0;
                    q_uld = 0;
                end
            end
        end
    end

    task automatic set_req_str(input string s);
        cur_req.delete();
        for (int i = 0; i < s.len(); i++) cur_req.push_back(s[i]);
    endtask

    task automatic clear_att();
        cur_att_len.delete();
        cur_att_data.delete();
    endtask

    task automatic add_att(input string s);
        cur_att_len.push_back(s.len());
        for (int i = 0; i < s.len(); i++) cur_att_data.push_back(s[i]);
    endtask

    task automatic load_req();
        @(posedge clk); #1;
        req_clear = 1'b1;
        @(posedge clk); #1;
        req_clear = 1'b0;
        foreach (cur_req[i]) begin
            req_wr_en   = 1'b1;
            req_wr_data = cur_req[i];
            @(posedge clk); #1;
        end
        req_wr_en = 1'b0;
        check("req_len_loaded", req_len, cur_req.size());
    endtask

    task automatic arm_query();
        model_query();
        uart_att_len  = cur_att_len;
        uart_att_data = cur_att_data;
        rx_pend.delete();
        sent_count = 0;
        cur_len    = cur_req.size();
    endtask

    task automatic fire_and_wait(input bit poke);
        int target, budget;
        arm_query();
        target = n_complete + 1;
        @(posedge clk); #1;
        start     = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        if (poke) begin
            // start, write and clear while busy must all be ignored
            repeat (2) begin @(posedge clk); #1; end
            start = 1'b1; req_wr_en = 1'b1; req_clear = 1'b1; req_wr_data = 8'h55;
            @(posedge clk); #1;
            start = 1'b0; req_wr_en = 1'b0; req_clear = 1'b0;
            check("req_len_busy_hold", req_len, cur_req.size());
        end
        budget = 4000;
        while (n_complete < target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("complete_seen", n_complete, target);
        if (cur_req.size() == 0) check("empty_start_latency", complete_cyc - start_cyc, 1);
        @(negedge clk);
        check("busy_after", busy, 0);
        check("hold_true", result_true, cur_exp.rt);
        check("hold_false", result_false, cur_exp.rf);
        check("hold_timed_out", timed_out, cur_exp.to);
    endtask

    task automatic random_attempts();
        int         n_att, nj, ender;
        logic [7:0] c;
        clear_att();
        n_att = $urandom_range(0, 3);
        for (int a = 0; a < n_att; a++) begin
            nj    = $urandom_range(0, 2);
            ender = $urandom_range(0, 3);
            cur_att_len.push_back(nj + ((ender != 3) ? 1 : 0));
            for (int j = 0; j < nj; j++) begin
                do c = 8'($urandom_range(32, 126)); while (c == TRUE_C || c == FALSE_C);
                cur_att_data.push_back(c);
            end
            if (ender == 0) cur_att_data.push_back(TRUE_C);
            if (ender == 1) cur_att_data.push_back(FALSE_C);
            if (ender == 2) cur_att_data.push_back(TERM_C);
        end
    endtask

    initial begin
        int base, budget, n;
        reset = 1'b0; req_clear = 1'b0; req_wr_en = 1'b0; req_wr_data = 8'h00; start = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_len", req_len, 0);
        check("rst_req_full", req_full, 0);
        check("rst_busy", busy, 0);
        check("rst_ld", ld_tx_data, 0);
        check("rst_uld", uld_rx_data, 0);
        check("rst_complete", complete, 0);
        check("rst_result_true", result_true, 0);
        check("rst_result_false", result_false, 0);
        check("rst_timed_out", timed_out, 0);
        check("rst_last_byte", last_byte, 0);
        reset = 1'b1;

        // "GET\n", reply 't', with busy-time pokes
        set_req_str("GET\n"); load_req();
        clear_att(); add_att("t");
        fire_and_wait(1'b1);

        // Reply "xyf"
        clear_att(); add_att("xyf");
        fire_and_wait(1'b0);

        // Silence: sent twice, then timed_out
        clear_att();
        fire_and_wait(1'b0);

        // Terminator then 't'
        clear_att(); add_att("\n"); add_att("t");
        fire_and_wait(1'b0);

        // Buffer fill to the limit; the 65th write is dropped
        cur_req.delete();
        @(posedge clk); #1; req_clear = 1'b1;
        @(posedge clk); #1; req_clear = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            if (i == DEPTH - 1) begin
                check("req_len_63", req_len, DEPTH - 1);
                check("req_full_63", req_full, 0);
            end
            cur_req.push_back(8'($urandom));
            req_wr_en   = 1'b1;
            req_wr_data = cur_req[i];
            @(posedge clk); #1;
        end
        req_wr_en = 1'b0;
        check("req_len_full", req_len, DEPTH);
        check("req_full_full", req_full, 1);
        void'(cur_req.pop_back());
        clear_att(); add_att("f");
        fire_and_wait(1'b0);

        // Clear wins over a simultaneous write
        req_clear = 1'b1; req_wr_en = 1'b1; req_wr_data = 8'hA5;
        @(posedge clk); #1;
        req_clear = 1'b0; req_wr_en = 1'b0;
        check("clear_wins_len", req_len, 0);
        check("clear_wins_full", req_full, 0);
        cur_req.delete(); clear_att();
        fire_and_wait(1'b0);

        // Reset during transmission of byte 2
        set_req_str("ABCD"); load_req();
        clear_att(); add_att("t");
        arm_query();
        base = ld_total;
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        budget = 200;
        while (ld_total < base + 2 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("ld_before_reset", ld_total - base, 2);
        reset = 1'b0;
        #1;
        check("midrst_ld", ld_tx_data, 0);
        check("midrst_busy", busy, 0);
        check("midrst_req_len", req_len, 0);
        check("midrst_uld", uld_rx_data, 0);
        check("midrst_complete", complete, 0);
        check("midrst_last_byte", last_byte, 0);
        exp_tx.delete();
        exp_done.delete();
        exp_last = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("postrst_req_len", req_len, 0);
        cur_req.delete(); clear_att();
        fire_and_wait(1'b0);

        // Randomised queries
        for (int t = 0; t < 14; t++) begin
            cur_req.delete();
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) cur_req.push_back(8'($urandom));
            load_req();
            random_attempts();
            fire_and_wait(t[0]);
        end

        repeat (5) @(negedge clk);
        check("tx_queue_drained", exp_tx.size(), 0);
        check("done_queue_drained", exp_done.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
